// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step cycles, $4017 field layout and mode encoding.
// Imported by the frame sequencer and by the channel instances it clocks.
package apu_pkg;

    localparam int STEP1    = 7457;
    localparam int STEP2    = 14913;
    localparam int STEP3    = 22371;
    localparam int STEP4    = 29829;
    localparam int STEP5    = 37281;
    localparam int WR_DELAY = 3;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } seq_mode_e;

    localparam int MODE_BIT    = 7;
    localparam int INHIBIT_BIT = 6;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: counts CPU cycles, emits quarter/half-frame clocks to the channels
// and raises the frame IRQ. Reconfigured through delayed-effect writes to $4017.
module apu_frame_sequencer #(
    parameter int CNT_W    = 16,
    parameter int STEP1    = apu_pkg::STEP1,
    parameter int STEP2    = apu_pkg::STEP2,
    parameter int STEP3    = apu_pkg::STEP3,
    parameter int STEP4    = apu_pkg::STEP4,
    parameter int STEP5    = apu_pkg::STEP5,
    parameter int WR_DELAY = apu_pkg::WR_DELAY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_ce,
    input  logic       wr_4017,
    input  logic [7:0] wr_data,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode
);
    import apu_pkg::*;

    localparam int               DLY_W    = $clog2(WR_DELAY + 1);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WR_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DLY_W-1:0] delay, delay_nxt;
    logic             mode_nxt;
    logic             irq_inhibit, irq_inhibit_nxt;
    logic             pending, pending_nxt;
    logic             pending_mode, pending_mode_nxt;
    logic             just_wrapped, just_wrapped_nxt;
    logic             quarter_nxt, half_nxt, irq_nxt;
    logic             step_q, step_h, at_wrap, irq_window;
    logic             inhibit_eff, apply, irq_set;
    logic             unused_wr_bits;

    assign unused_wr_bits = ^wr_data[5:0];

    // Step decode on the pre-increment count.
    always_comb begin
        step_q = 1'b0;
        step_h = 1'b0;
        if (cnt == CNT_W'(STEP1) || cnt == CNT_W'(STEP3)) begin
            step_q = 1'b1;
        end else if (cnt == CNT_W'(STEP2)) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end else if (mode == MODE_4STEP && cnt == CNT_W'(STEP4)) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end else if (mode == MODE_5STEP && cnt == CNT_W'(STEP5)) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end
        at_wrap    = (mode == MODE_5STEP) ? (cnt == CNT_W'(STEP5)) : (cnt == CNT_W'(STEP4));
        // cnt == 0 only counts as the third IRQ cycle when it follows a natural wrap.
        irq_window = (cnt == CNT_W'(STEP4 - 1)) || (cnt == CNT_W'(STEP4)) ||
                     (cnt == '0 && just_wrapped);
    end

    always_comb begin
        cnt_nxt          = cnt;
        delay_nxt        = delay;
        mode_nxt         = mode;
        irq_inhibit_nxt  = irq_inhibit;
        pending_nxt      = pending;
        pending_mode_nxt = pending_mode;
        just_wrapped_nxt = just_wrapped;
        quarter_nxt      = 1'b0;
        half_nxt         = 1'b0;
        irq_set          = 1'b0;
        // A write on this clk both restarts the delay and takes effect on the inhibit at once.
        inhibit_eff      = wr_4017 ? wr_data[INHIBIT_BIT] : irq_inhibit;
        apply            = cpu_ce && !wr_4017 && pending && (delay == DLY_ONE);

        if (cpu_ce) begin
            if (apply) begin
                cnt_nxt          = '0;
                mode_nxt         = pending_mode;
                pending_nxt      = 1'b0;
                delay_nxt        = '0;
                just_wrapped_nxt = 1'b0;
                quarter_nxt      = pending_mode;
                half_nxt         = pending_mode;
            end else begin
                cnt_nxt          = at_wrap ? '0 : cnt + 1'b1;
                just_wrapped_nxt = at_wrap;
                quarter_nxt      = step_q;
                half_nxt         = step_h;
                irq_set          = irq_window && (mode == MODE_4STEP) && !inhibit_eff;
                if (pending && !wr_4017 && delay != '0) begin
                    delay_nxt = delay - 1'b1;
                end
            end
        end

        if (wr_4017) begin
            irq_inhibit_nxt  = wr_data[INHIBIT_BIT];
            pending_nxt      = 1'b1;
            pending_mode_nxt = wr_data[MODE_BIT];
            delay_nxt        = DLY_INIT;
        end

        irq_nxt = frame_irq;
        if (irq_set) begin
            irq_nxt = 1'b1;
        end else if (status_rd || (wr_4017 && wr_data[INHIBIT_BIT])) begin
            irq_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            delay         <= '0;
            mode          <= 1'b0;
            irq_inhibit   <= 1'b0;
            pending       <= 1'b0;
            pending_mode  <= 1'b0;
            just_wrapped  <= 1'b0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
            frame_irq     <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            delay         <= delay_nxt;
            mode          <= mode_nxt;
            irq_inhibit   <= irq_inhibit_nxt;
            pending       <= pending_nxt;
            pending_mode  <= pending_mode_nxt;
            just_wrapped  <= just_wrapped_nxt;
            quarter_frame <= quarter_nxt;
            half_frame    <= half_nxt;
            frame_irq     <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: scripted CPU-cycle stimulus with per-clk expected
// {frame_irq, mode, half_frame, quarter_frame} pushed to a queue and popped on the falling edge.
module tb_apu_frame_sequencer;

    localparam int S1 = 7457;
    localparam int S2 = 14913;
    localparam int S3 = 22371;
    localparam int S4 = 29829;
    localparam int S5 = 37281;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_ce = 1'b0;
    logic       wr_4017 = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       status_rd = 1'b0;
    logic       quarter_frame, half_frame, frame_irq, mode;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    string      tag_q[$];
    int         pos;
    logic       e_mode;
    logic       e_irq;

    apu_frame_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_ce       (cpu_ce),
        .wr_4017      (wr_4017),
        .wr_data      (wr_data),
        .status_rd    (status_rd),
        .quarter_frame(quarter_frame),
        .half_frame   (half_frame),
        .frame_irq    (frame_irq),
        .mode         (mode)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {irq,mode,half,quarter}=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {half, quarter} expected for a counting cpu_ce at position p
    function automatic logic [1:0] step_pulses(input int p, input logic five);
        case (p)
            S1:      return 2'b01;
            S2:      return 2'b11;
            S3:      return 2'b01;
            S4:      return five ? 2'b00 : 2'b11;
            S5:      return five ? 2'b11 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    // driver: one clk of stimulus; expectation queued at the edge that consumes it
    task automatic cyc(input logic ce, input logic wr, input logic [7:0] d, input logic rd,
                       input logic [1:0] pulses, input string tag);
        cpu_ce    = ce;
        wr_4017   = wr;
        wr_data   = d;
        status_rd = rd;
        @(posedge clk);
        exp_q.push_back({e_irq, e_mode, pulses});
        tag_q.push_back(tag);
        #1;
        cpu_ce    = 1'b0;
        wr_4017   = 1'b0;
        status_rd = 1'b0;
    endtask

    task automatic step_ce(input logic wr, input logic [7:0] d, input logic rd, input string tag);
        logic [1:0] p;
        p = step_pulses(pos, e_mode);
        pos = (pos == (e_mode ? S5 : S4)) ? 0 : pos + 1;
        cyc(1'b1, wr, d, rd, p, tag);
    endtask

    task automatic idle(input logic wr, input logic [7:0] d, input logic rd, input string tag);
        cyc(1'b0, wr, d, rd, 2'b00, tag);
    endtask

    // cpu_ce on which the delayed $4017 write lands; e_mode already holds the new mode
    task automatic reset_ce(input string tag);
        pos = 0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, e_mode ? 2'b11 : 2'b00, tag);
    endtask

    task automatic run_until(input int target, input string tag);
        int guard;
        guard = 0;
        while (pos != target && guard < 40000) begin
            step_ce(1'b0, 8'h00, 1'b0, tag);
            guard++;
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(), {frame_irq, mode, half_frame, quarter_frame}, exp_q.pop_front());
        end
    end

    initial begin
        pos    = 0;
        e_mode = 1'b0;
        e_irq  = 1'b0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {frame_irq, mode, half_frame, quarter_frame}, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("reset_release", {frame_irq, mode, half_frame, quarter_frame}, 4'b0000);

        // 4-step sequence from reset, IRQ window with read/inhibit interplay
        run_until(S4 - 1, "a_4step");
        e_irq = 1'b1;
        step_ce(1'b0, 8'h00, 1'b1, "a_irq_set_beats_rd");
        e_irq = 1'b0;
        idle(1'b1, 8'h40, 1'b0, "a_inhibit_clears");
        step_ce(1'b0, 8'h00, 1'b0, "a_step4_inhibited");
        idle(1'b1, 8'h00, 1'b0, "a_uninhibit");
        e_irq = 1'b1;
        step_ce(1'b0, 8'h00, 1'b0, "a_irq_at_wrap0");
        step_ce(1'b0, 8'h00, 1'b0, "a_delay");
        reset_ce("a_ctr_reset_m4");
        e_irq = 1'b0;
        idle(1'b0, 8'h00, 1'b1, "a_rd_clears");
        repeat (10) step_ce(1'b0, 8'h00, 1'b0, "a_no_irq_after_reset0");

        // rewrite while pending; write coincident with cpu_ce is not counted
        idle(1'b1, 8'h80, 1'b0, "c_wr80");
        repeat (2) step_ce(1'b0, 8'h00, 1'b0, "c_pending");
        step_ce(1'b1, 8'h00, 1'b0, "c_wr00_on_ce");
        repeat (2) step_ce(1'b0, 8'h00, 1'b0, "c_restarted");
        reset_ce("c_reset_m4_no_pulse");
        repeat (3) step_ce(1'b0, 8'h00, 1'b0, "c_after");

        // 5-step mode over a full period, with random cpu_ce gaps early on
        idle(1'b1, 8'h80, 1'b0, "d_wr80");
        repeat (2) begin
            step_ce(1'b0, 8'h00, 1'b0, "d_pending");
            repeat ($urandom_range(0, 2)) idle(1'b0, 8'h00, 1'($urandom_range(0, 1)), "d_gap");
        end
        e_mode = 1'b1;
        reset_ce("d_reset_m5_pulse");
        repeat (60) begin
            step_ce(1'b0, 8'h00, 1'b0, "d_early");
            repeat ($urandom_range(0, 1)) idle(1'b0, 8'h00, 1'($urandom_range(0, 1)), "d_gap");
        end
        run_until(S5, "d_5step");
        step_ce(1'b0, 8'h00, 1'b0, "d_step5_wrap");
        repeat (5) step_ce(1'b0, 8'h00, 1'b0, "d_after_wrap");

        // asynchronous reset with a write pending
        run_until(100, "e_run");
        idle(1'b1, 8'h80, 1'b0, "e_wr_pending");
        step_ce(1'b0, 8'h00, 1'b0, "e_pending");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("e_rst_async", {frame_irq, mode, half_frame, quarter_frame}, 4'b0000);
        cpu_ce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cpu_ce = 1'b0;
        rst_n  = 1'b1;
        check("e_rst_held", {frame_irq, mode, half_frame, quarter_frame}, 4'b0000);
        pos    = 0;
        e_mode = 1'b0;
        e_irq  = 1'b0;
        repeat (6) step_ce(1'b0, 8'h00, 1'b0, "e_pending_dropped");
        run_until(S1, "e_restart");
        step_ce(1'b0, 8'h00, 1'b0, "e_q_step1");

        // final report
        repeat (3) @(negedge clk);
        check("drain", {3'b000, exp_q.size() != 0}, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
